// File: rtl/sha256_pkg.sv
// Shared SHA-256 scheduler-control definitions: FSM states, block geometry, W[t] beat payload.
package sha256_pkg;

    localparam int unsigned SHA256_MSG_WORDS         = 16;
    localparam int unsigned SHA256_ROUNDS            = 64;
    localparam int unsigned SHA256_SCHED_CALC_CYCLES = 5;
    localparam int unsigned SHA256_WORD_W            = 32;
    localparam int unsigned SHA256_ROUND_W           = 6;
    localparam int unsigned SHA256_ADDR_W            = 4;
    localparam int unsigned SHA256_LOAD_W            = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        CALC,
        HOLD,
        DONE
    } sched_state_e;

    typedef struct packed {
        logic [SHA256_WORD_W-1:0]  data;
        logic [SHA256_ROUND_W-1:0] round;
    } wt_beat_t;

endpackage

// File: rtl/sha256_sched_ctrl.sv
// Loads a 16-word block into message_scheduler, steps round_t 0..63 and streams W[t] out.
// Optional abort input enabled by defining SHA256_SCHED_ABORT_EN.
module sha256_sched_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned CALC_CYCLES = SHA256_SCHED_CALC_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      msg_valid,
    output logic                      msg_ready,
    input  logic [SHA256_WORD_W-1:0]  msg_data,
    output logic                      sch_start_new_block,
    output logic [SHA256_ROUND_W-1:0] sch_round_t,
    output logic [SHA256_WORD_W-1:0]  sch_word_in,
    output logic [SHA256_ADDR_W-1:0]  sch_word_addr,
    output logic                      sch_we,
    input  logic [SHA256_WORD_W-1:0]  sch_wt,
    output logic                      wt_valid,
    input  logic                      wt_ready,
    output logic [SHA256_WORD_W-1:0]  wt_data,
    output logic [SHA256_ROUND_W-1:0] wt_round,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CALC_W = (CALC_CYCLES > 2) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CALC_W-1:0]         CALC_LAST  = CALC_W'(CALC_CYCLES - 1);
    localparam logic [SHA256_LOAD_W-1:0]  LOAD_LAST  = SHA256_LOAD_W'(SHA256_MSG_WORDS - 1);
    localparam logic [SHA256_ROUND_W-1:0] FETCH_LAST = SHA256_ROUND_W'(SHA256_MSG_WORDS - 1);
    localparam logic [SHA256_ROUND_W-1:0] ROUND_LAST = SHA256_ROUND_W'(SHA256_ROUNDS - 1);

    sched_state_e              state_q, state_d;
    logic [SHA256_ROUND_W-1:0] t_q, t_d;
    logic [SHA256_LOAD_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CALC_W-1:0]         calc_cnt_q, calc_cnt_d;
    wt_beat_t                  beat_q, beat_d;
    logic                      msg_ready_q, msg_ready_d;
    logic [SHA256_ROUND_W-1:0] sch_round_q, sch_round_d;
    logic                      wt_valid_q, wt_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    assign sch_we              = msg_valid && msg_ready_q;
    assign sch_word_in         = msg_data;
    assign sch_word_addr       = load_cnt_q[SHA256_ADDR_W-1:0];
    assign msg_ready           = msg_ready_q;
    assign sch_start_new_block = msg_ready_q;
    assign sch_round_t         = sch_round_q;
    assign wt_valid            = wt_valid_q;
    assign wt_data             = beat_q.data;
    assign wt_round            = beat_q.round;
    assign busy                = busy_q;
    assign done                = done_q;

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        load_cnt_d = load_cnt_q;
        calc_cnt_d = calc_cnt_q;
        beat_d     = beat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                    t_d        = '0;
                end
            end
            LOAD: begin
                if (sch_we) begin
                    load_cnt_d = load_cnt_q + SHA256_LOAD_W'(1);
                    if (load_cnt_q == LOAD_LAST) state_d = FETCH;
                end
            end
            FETCH: begin
                beat_d.data  = sch_wt;
                beat_d.round = t_q;
                state_d      = HOLD;
            end
            CALC: begin
                // Final accumulate edge coincides with the scheduler write-back of W[t].
                if (calc_cnt_q == CALC_LAST) begin
                    calc_cnt_d   = '0;
                    beat_d.data  = sch_wt;
                    beat_d.round = t_q;
                    state_d      = HOLD;
                end else begin
                    calc_cnt_d = calc_cnt_q + CALC_W'(1);
                end
            end
            HOLD: begin
                if (wt_valid_q && wt_ready) begin
                    if (t_q == ROUND_LAST) begin
                        state_d = DONE;
                    end else begin
                        t_d     = t_q + SHA256_ROUND_W'(1);
                        state_d = (t_q < FETCH_LAST) ? FETCH : CALC;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SHA256_SCHED_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            calc_cnt_d = '0;
        end
`endif

        // Round is parked at 0 outside FETCH/CALC so a stalled round >=16 never re-arms the scheduler.
        msg_ready_d = (state_d == LOAD);
        sch_round_d = ((state_d == FETCH) || (state_d == CALC)) ? t_d : '0;
        wt_valid_d  = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            t_q         <= '0;
            load_cnt_q  <= '0;
            calc_cnt_q  <= '0;
            beat_q      <= '0;
            msg_ready_q <= 1'b0;
            sch_round_q <= '0;
            wt_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            load_cnt_q  <= load_cnt_d;
            calc_cnt_q  <= calc_cnt_d;
            beat_q      <= beat_d;
            msg_ready_q <= msg_ready_d;
            sch_round_q <= sch_round_d;
            wt_valid_q  <= wt_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Directed bench for sha256_sched_ctrl with a behavioural message_scheduler beside it.
module tb_sha256_sched_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] msg_data;
    logic        sch_start_new_block;
    logic [5:0]  sch_round_t;
    logic [31:0] sch_word_in;
    logic [3:0]  sch_word_addr;
    logic        sch_we;
    logic [31:0] sch_wt;
    logic        wt_valid;
    logic        wt_ready;
    logic [31:0] wt_data;
    logic [5:0]  wt_round;
    logic        busy;
    logic        done;
`ifdef SHA256_SCHED_ABORT_EN
    logic        abort;
`endif

    always #5 clk = ~clk;

    sha256_sched_ctrl dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
`ifdef SHA256_SCHED_ABORT_EN
        .abort               (abort),
`endif
        .msg_valid           (msg_valid),
        .msg_ready           (msg_ready),
        .msg_data            (msg_data),
        .sch_start_new_block (sch_start_new_block),
        .sch_round_t         (sch_round_t),
        .sch_word_in         (sch_word_in),
        .sch_word_addr       (sch_word_addr),
        .sch_we              (sch_we),
        .sch_wt              (sch_wt),
        .wt_valid            (wt_valid),
        .wt_ready            (wt_ready),
        .wt_data             (wt_data),
        .wt_round            (wt_round),
        .busy                (busy),
        .done                (done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Scheduler model: W[t>=16] is valid only on the 5th edge of a held round, then written back.
    logic [31:0] mem [64];
    int          hold_cnt = 0;
    logic [5:0]  prev_rt  = '0;

    always_comb begin
        if (sch_round_t < 6'd16)
            sch_wt = mem[sch_round_t];
        else if (hold_cnt == 4)
            sch_wt = ssig1(mem[sch_round_t - 6'd2]) + mem[sch_round_t - 6'd7]
                   + ssig0(mem[sch_round_t - 6'd15]) + mem[sch_round_t - 6'd16];
        else
            sch_wt = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (sch_we) mem[{2'b00, sch_word_addr}] <= sch_word_in;
        if (sch_round_t >= 6'd16) begin
            hold_cnt <= (sch_round_t == prev_rt) ? hold_cnt + 1 : 1;
            if (hold_cnt == 4) mem[sch_round_t] <= sch_wt;
        end else begin
            hold_cnt <= 0;
        end
        prev_rt <= sch_round_t;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] blk [16];
    logic [31:0] expw [64];
    logic [31:0] got [64];
    bit          saw_done;
    int          lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom();
    endtask

    task automatic compute_exp();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) expw[t] = blk[t];
            else expw[t] = ssig1(expw[t-2]) + expw[t-7] + ssig0(expw[t-15]) + expw[t-16];
        end
    endtask

    task automatic run_block(input string name, input bit toggle, input bit stall_mode,
                             input bit pulses, input int reset_at, input int abort_at);
        int  li, we_cnt, addr_err, park_err, stab_err, we_out, stall_cnt, nd, st_cyc;
        bit  prev_stall, cut;
        logic [31:0] prev_data;
        li = 0; we_cnt = 0; addr_err = 0; park_err = 0; stab_err = 0; we_out = 0;
        stall_cnt = 0; prev_stall = 0; cut = 0; prev_data = '0; saw_done = 0; lat = 0;
        for (int t = 0; t < 64; t++) got[t] = 'x;
        compute_exp();

        @(negedge clk);
        start = 1'b1; msg_valid = 1'b0; wt_ready = 1'b1; st_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_after_start"}, busy, 1);

        for (int g = 0; g < 200 && li < 16; g++) begin
            msg_valid = !toggle || (g % 2 == 0);
            msg_data  = blk[li];
            start     = pulses && (g == 5);
            #1;
            if (sch_we) begin
                if (sch_word_addr !== 4'(li)) addr_err++;
                we_cnt++;
                li++;
            end
            @(negedge clk);
        end
        msg_valid = 1'b0; start = 1'b0;
        chk({name, "_we_count"}, we_cnt, 16);
        chk({name, "_we_addr_order"}, addr_err, 0);

        for (int g = 0; g < 20000; g++) begin
            if (done) begin
                saw_done = 1;
                lat = cyc - st_cyc + 1;
                break;
            end
            if (reset_at >= 0 && sch_round_t == 6'(reset_at)) begin
                #2 msg_valid = 1'b1; reset_n = 1'b0;
                #1;
                chk({name, "_rst_busy"}, busy, 0);
                chk({name, "_rst_we"}, sch_we, 0);
                chk({name, "_rst_round"}, sch_round_t, 0);
                chk({name, "_rst_valid"}, wt_valid, 0);
                msg_valid = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                cut = 1;
                break;
            end
`ifdef SHA256_SCHED_ABORT_EN
            if (abort_at >= 0 && sch_round_t == 6'(abort_at)) begin
                abort = 1'b1; wt_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk({name, "_abort_busy"}, busy, 0);
                chk({name, "_abort_valid"}, wt_valid, 0);
                chk({name, "_abort_ready"}, msg_ready, 0);
                chk({name, "_abort_round"}, sch_round_t, 0);
                nd = 0;
                repeat (8) begin
                    if (done) nd++;
                    @(negedge clk);
                end
                chk({name, "_abort_no_done"}, nd, 0);
                cut = 1;
                break;
            end
`endif
            if (stall_mode) begin
                if (wt_valid && wt_round == 6'd16 && stall_cnt < 50) begin
                    wt_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    wt_ready = ($urandom_range(99) >= 30);
                end
            end else begin
                wt_ready = 1'b1;
            end
            start = pulses && (sch_round_t == 6'd30);
            #1;
            if (sch_we) we_out++;
            if (wt_valid && sch_round_t !== 6'd0) park_err++;
            if (prev_stall && wt_data !== prev_data) stab_err++;
            if (wt_valid && wt_ready) got[wt_round] = wt_data;
            prev_stall = wt_valid && !wt_ready;
            prev_data  = wt_data;
            @(negedge clk);
        end
        start = 1'b0;

        if (!cut) begin
            chk({name, "_done_seen"}, saw_done, 1);
            chk({name, "_park"}, park_err, 0);
            chk({name, "_stable"}, stab_err, 0);
            chk({name, "_we_outside_load"}, we_out, 0);
            for (int t = 0; t < 64; t++) chk($sformatf("%s_w%0d", name, t), got[t], expw[t]);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; msg_valid = 1'b0; msg_data = '0; wt_ready = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_wt_valid", wt_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_round", sch_round_t, 0);
        chk("rst_wt_data", wt_data, 0);
        chk("rst_wt_round", wt_round, 0);
        chk("rst_snb", sch_start_new_block, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        msg_valid = 1'b1;
        #1 chk("idle_no_we", sch_we, 0);
        msg_valid = 1'b0;

        set_abc();
        run_block("abc", 0, 0, 0, -1, -1);
        chk("abc_w0", got[0], 32'h6162_6380);
        chk("abc_w15", got[15], 32'h0000_0018);
        chk("abc_w16", got[16], 32'h6162_6380);
        chk("abc_w17", got[17], 32'h000F_0000);
        chk("abc_w18", got[18], 32'h7DA8_6405);
        chk("abc_w19", got[19], 32'h6000_03C6);
        chk("abc_start_to_done", lat, 338);

        set_abc();
        run_block("stall", 0, 1, 0, -1, -1);

        set_rand();
        run_block("loadbp", 1, 0, 1, -1, -1);

        set_rand();
        run_block("b2b", 0, 0, 0, -1, -1);
        chk("b2b_w63", got[63], expw[63]);

        set_rand();
        run_block("midrst", 0, 0, 0, 20, -1);
        set_abc();
        run_block("after_rst", 0, 0, 0, -1, -1);

`ifdef SHA256_SCHED_ABORT_EN
        set_rand();
        run_block("abort", 0, 0, 0, -1, 40);
        set_rand();
        run_block("after_abort", 0, 0, 0, -1, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
